// File: rtl/pkt_demux_pipe_pkg.sv
// Shared beat-format constants, FSM state type and beat-count helper for pkt_demux_pipe.
package pkt_demux_pipe_pkg;

   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned LEN_W_DEF  = 16;
   localparam int unsigned LEN_LSB    = 0;
   localparam int unsigned DEST_BIT   = LEN_LSB + LEN_W_DEF;

   typedef enum logic {
      HDR  = 1'b0,
      BODY = 1'b1
   } state_e;

   // Beats in a packet of len bytes, 2**shift bytes per beat; len 0 counts as one beat.
   function automatic logic [31:0] beats_of(input logic [31:0] len, input int unsigned shift);
      logic [31:0] mask;
      logic [31:0] beats;
      mask  = (32'd1 << shift) - 32'd1;
      beats = len >> shift;
      if ((len & mask) != 32'd0) beats = beats + 32'd1;
      if (beats == 32'd0) beats = 32'd1;
      return beats;
   endfunction

endpackage

// File: rtl/pkt_demux_pipe_fifo2.sv
// Two-entry FIFO with registered enqueue-ready; no bypass when full.
module fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enq_ena_i,
   input  logic [WIDTH-1:0] enq_data_i,
   output logic             enq_rdy_o,
   input  logic             deq_ena_i,
   output logic [WIDTH-1:0] first_o,
   output logic             deq_rdy_o
);

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] d0_q, d0_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic             rdy_q;

   always_comb begin
      count_d = count_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      unique case ({enq_ena_i, deq_ena_i})
         2'b10: begin
            if (count_q == 2'd0) d0_d = enq_data_i;
            else                 d1_d = enq_data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            d0_d    = d1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               d0_d = enq_data_i;
            end else begin
               d0_d = d1_q;
               d1_d = enq_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         rdy_q   <= 1'b1;
      end else begin
         count_q <= count_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         rdy_q   <= (count_d != 2'd2);
      end
   end

   assign enq_rdy_o = rdy_q;
   assign first_o   = d0_q;
   assign deq_rdy_o = (count_q != 2'd0);

endmodule

// File: rtl/pkt_demux_pipe.sv
// Whole-packet demultiplexer to two outputs, routed by the header beat's dest bit.
// Optional per-output packet counters: define PKT_DEMUX_PIPE_STATS_EN.
module pkt_demux_pipe
   import pkt_demux_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                            CLK,
   input  logic                            nRST,
   input  logic                            in_enq__ENA,
   input  logic [DATA_WIDTH+LEN_WIDTH-1:0] in_enq_v,
   output logic                            in_enq__RDY,
   output logic                            out0_enq__ENA,
   output logic [DATA_WIDTH+LEN_WIDTH-1:0] out0_enq_v,
   input  logic                            out0_enq__RDY,
   output logic                            out1_enq__ENA,
   output logic [DATA_WIDTH+LEN_WIDTH-1:0] out1_enq_v,
   input  logic                            out1_enq__RDY
`ifdef PKT_DEMUX_PIPE_STATS_EN
   ,
   output logic [31:0]                     stat_pkt0,
   output logic [31:0]                     stat_pkt1
`endif
);

   localparam int unsigned W        = DATA_WIDTH + LEN_WIDTH;
   localparam int unsigned SHIFT    = $clog2(DATA_WIDTH / 8);
   localparam int unsigned CNT_W    = LEN_WIDTH - SHIFT;
   localparam int unsigned DEST_POS = LEN_LSB + LEN_WIDTH;

   logic [W-1:0]     head;
   logic             head_valid;
   logic             deq;
   logic             sel;
   logic             sel_rdy;
   logic [31:0]      len32;
   logic [31:0]      left32;
   logic [CNT_W-1:0] hdr_left;
   logic             unused_left_hi;

   state_e           state_q, state_d;
   logic             route_q, route_d;
   logic [CNT_W-1:0] left_q, left_d;

   fifo2 #(.WIDTH(W)) u_fifo (
      .clk_i      (CLK),
      .rst_ni     (nRST),
      .enq_ena_i  (in_enq__ENA),
      .enq_data_i (in_enq_v),
      .enq_rdy_o  (in_enq__RDY),
      .deq_ena_i  (deq),
      .first_o    (head),
      .deq_rdy_o  (head_valid)
   );

   // beats-1 always fits the counter even when beats itself (e.g. 4096) does not
   assign len32          = 32'(head[LEN_LSB +: LEN_WIDTH]);
   assign left32         = beats_of(len32, SHIFT) - 32'd1;
   assign hdr_left       = left32[CNT_W-1:0];
   assign unused_left_hi = ^left32[31:CNT_W];

   always_comb begin
      sel     = (state_q == HDR) ? head[DEST_POS] : route_q;
      sel_rdy = sel ? out1_enq__RDY : out0_enq__RDY;
      deq     = head_valid && sel_rdy;
      state_d = state_q;
      route_d = route_q;
      left_d  = left_q;
      unique case (state_q)
         HDR: begin
            if (head_valid) begin
               route_d = head[DEST_POS];
               left_d  = hdr_left;
               if (deq && (hdr_left != '0)) state_d = BODY;
            end
         end
         BODY: begin
            if (deq) begin
               left_d = left_q - CNT_W'(1);
               if (left_q == CNT_W'(1)) state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= HDR;
         route_q <= 1'b0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         left_q  <= left_d;
      end
   end

   assign out0_enq__ENA = deq && !sel;
   assign out1_enq__ENA = deq && sel;
   assign out0_enq_v    = (head_valid && !sel) ? head : '0;
   assign out1_enq_v    = (head_valid && sel) ? head : '0;

`ifdef PKT_DEMUX_PIPE_STATS_EN
   logic        pkt_done;
   logic [31:0] stat0_q;
   logic [31:0] stat1_q;

   assign pkt_done = deq && (((state_q == HDR) && (hdr_left == '0)) ||
                             ((state_q == BODY) && (left_q == CNT_W'(1))));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat0_q <= '0;
         stat1_q <= '0;
      end else if (pkt_done) begin
         if (sel) stat1_q <= stat1_q + 32'd1;
         else     stat0_q <= stat0_q + 32'd1;
      end
   end

   assign stat_pkt0 = stat0_q;
   assign stat_pkt1 = stat1_q;
`endif

endmodule

// File: tb/tb_pkt_demux_pipe.sv
// Directed self-checking bench for pkt_demux_pipe (stats checks need PKT_DEMUX_PIPE_STATS_EN).
module tb_pkt_demux_pipe;

   localparam int unsigned W = 144;

   logic         CLK;
   logic         nRST;
   logic         in_ena;
   logic [W-1:0] in_v;
   logic         in_rdy;
   logic         o0_ena, o1_ena;
   logic [W-1:0] o0_v, o1_v;
   logic         o0_rdy, o1_rdy;
`ifdef PKT_DEMUX_PIPE_STATS_EN
   logic [31:0]  st0, st1;
`endif

   int total;
   int bad;
   int both_ena;
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];

   pkt_demux_pipe #(.DATA_WIDTH(128), .LEN_WIDTH(16)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .in_enq__ENA   (in_ena),
      .in_enq_v      (in_v),
      .in_enq__RDY   (in_rdy),
      .out0_enq__ENA (o0_ena),
      .out0_enq_v    (o0_v),
      .out0_enq__RDY (o0_rdy),
      .out1_enq__ENA (o1_ena),
      .out1_enq_v    (o1_v),
      .out1_enq__RDY (o1_rdy)
`ifdef PKT_DEMUX_PIPE_STATS_EN
      ,
      .stat_pkt0     (st0),
      .stat_pkt1     (st1)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ENA seen at a falling edge means the transfer completes at the next rising edge
   always @(negedge CLK) begin
      if (o0_ena) q0.push_back(o0_v);
      if (o1_ena) q1.push_back(o1_v);
      if (o0_ena && o1_ena) both_ena++;
   end

   function automatic logic [W-1:0] mk(input logic [15:0] tag, input logic dest, input logic [15:0] len);
      logic [W-1:0] r;
      r        = '0;
      r[15:0]  = len;
      r[16]    = dest;
      r[32:17] = tag;
      return r;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic put(input logic [W-1:0] b);
      int unsigned n;
      n = 0;
      while (!in_rdy && n < 100) begin
         step();
         n++;
      end
      if (!in_rdy) begin
         total++;
         bad++;
         $display("FAIL put_timeout: in_rdy=%0b required=1", in_rdy);
      end else begin
         in_ena = 1'b1;
         in_v   = b;
         step();
         in_ena = 1'b0;
         in_v   = '0;
      end
   endtask

   task automatic test_reset();
      repeat (2) step();
      nRST = 1'b1;
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy: got %0b want 1", in_rdy); end
      total++; if (o0_ena !== 1'b0) begin bad++; $display("FAIL rst_o0_ena: got %0b want 0", o0_ena); end
      total++; if (o1_ena !== 1'b0) begin bad++; $display("FAIL rst_o1_ena: got %0b want 0", o1_ena); end
      total++; if (o0_v !== '0) begin bad++; $display("FAIL rst_o0_v: got %h want 0", o0_v); end
      total++; if (o1_v !== '0) begin bad++; $display("FAIL rst_o1_v: got %h want 0", o1_v); end
      step();
   endtask

   task automatic test_single();
      logic [W-1:0] b;
      b = mk(16'h0011, 1'b1, 16'd16);
      put(b);
      @(negedge CLK);
      total++; if (o1_ena !== 1'b1) begin bad++; $display("FAIL single_o1_ena: got %0b want 1", o1_ena); end
      total++; if (o0_ena !== 1'b0) begin bad++; $display("FAIL single_o0_ena: got %0b want 0", o0_ena); end
      total++; if (o1_v !== b) begin bad++; $display("FAIL single_o1_v: got %h want %h", o1_v, b); end
      total++; if (o0_v !== '0) begin bad++; $display("FAIL single_o0_v: got %h want 0", o0_v); end
      step();
      @(negedge CLK);
      total++; if (o1_ena !== 1'b0) begin bad++; $display("FAIL single_after: got %0b want 0", o1_ena); end
      step();
      q0.delete();
      q1.delete();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] b[4];
      b[0] = mk(16'h0100, 1'b0, 16'd40);
      b[1] = mk(16'h0101, 1'b1, 16'hFFFF);
      b[2] = mk(16'h0102, 1'b1, 16'd5);
      b[3] = mk(16'h0200, 1'b1, 16'd1);
      for (int i = 0; i < 4; i++) put(b[i]);
      step();
      total++; if (q0.size() !== 3) begin bad++; $display("FAIL b2b_q0_size: got %0d want 3", q0.size()); end
      total++; if (q1.size() !== 1) begin bad++; $display("FAIL b2b_q1_size: got %0d want 1", q1.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < q0.size()) begin
            total++; if (q0[i] !== b[i]) begin bad++; $display("FAIL b2b_q0_beat%0d: got %h want %h", i, q0[i], b[i]); end
         end
      end
      if (q1.size() > 0) begin
         total++; if (q1[0] !== b[3]) begin bad++; $display("FAIL b2b_q1_beat: got %h want %h", q1[0], b[3]); end
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic test_stall();
      logic [W-1:0] b[3];
      b[0] = mk(16'h0300, 1'b0, 16'd48);
      b[1] = mk(16'h0301, 1'b1, 16'd0);
      b[2] = mk(16'h0302, 1'b1, 16'd7);
      o0_rdy = 1'b0;
      put(b[0]);
      put(b[1]);
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL stall_full: in_rdy=%0b want 0", in_rdy); end
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         total++; if (o0_ena !== 1'b0 || o1_ena !== 1'b0) begin bad++; $display("FAIL stall_ena c%0d: o0=%0b o1=%0b want 0 0", c, o0_ena, o1_ena); end
         total++; if (o0_v !== b[0]) begin bad++; $display("FAIL stall_head c%0d: got %h want %h", c, o0_v, b[0]); end
         step();
      end
      o0_rdy = 1'b1;
      @(negedge CLK);
      total++; if (o0_ena !== 1'b1) begin bad++; $display("FAIL stall_release: o0_ena=%0b want 1", o0_ena); end
      step();
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL stall_rdy_rise: in_rdy=%0b want 1", in_rdy); end
      put(b[2]);
      repeat (3) step();
      total++; if (q0.size() !== 3) begin bad++; $display("FAIL stall_q0_size: got %0d want 3", q0.size()); end
      total++; if (q1.size() !== 0) begin bad++; $display("FAIL stall_q1_size: got %0d want 0", q1.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < q0.size()) begin
            total++; if (q0[i] !== b[i]) begin bad++; $display("FAIL stall_order%0d: got %h want %h", i, q0[i], b[i]); end
         end
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic test_long();
      logic [W-1:0] h0, h1, last_body, tail;
      h0   = mk(16'h0600, 1'b1, 16'd0);
      h1   = mk(16'h0601, 1'b0, 16'hFFFF);
      tail = mk(16'h0700, 1'b1, 16'd16);
      last_body = '0;
      put(h0);
      put(h1);
      for (int i = 1; i < 4096; i++) begin
         last_body = mk(16'(i), 1'b1, 16'd16);
         put(last_body);
      end
      put(tail);
      repeat (4) step();
      total++; if (q0.size() !== 4096) begin bad++; $display("FAIL long_q0_size: got %0d want 4096", q0.size()); end
      total++; if (q1.size() !== 2) begin bad++; $display("FAIL long_q1_size: got %0d want 2", q1.size()); end
      if (q1.size() == 2) begin
         total++; if (q1[0] !== h0) begin bad++; $display("FAIL long_zero_len: got %h want %h", q1[0], h0); end
         total++; if (q1[1] !== tail) begin bad++; $display("FAIL long_next_hdr: got %h want %h", q1[1], tail); end
      end
      if (q0.size() == 4096) begin
         total++; if (q0[4095] !== last_body) begin bad++; $display("FAIL long_last_body: got %h want %h", q0[4095], last_body); end
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] nb;
      logic [W-1:0] b2;
      b2 = mk(16'h0402, 1'b1, 16'd9);
      nb = mk(16'h0500, 1'b1, 16'd16);
      put(mk(16'h0400, 1'b0, 16'd64));
      put(mk(16'h0401, 1'b1, 16'd3));
      step();
      o0_rdy = 1'b0;
      put(b2);
      put(mk(16'h0403, 1'b1, 16'd2));
      total++; if (o0_v !== b2) begin bad++; $display("FAIL mid_queued: got %h want %h", o0_v, b2); end
      #1;
      o0_rdy = 1'b1;
      #1;
      total++; if (o0_ena !== 1'b1) begin bad++; $display("FAIL mid_pre_ena: got %0b want 1", o0_ena); end
      nRST = 1'b0;
      #1;
      total++; if (o0_ena !== 1'b0) begin bad++; $display("FAIL mid_rst_ena: got %0b want 0", o0_ena); end
      total++; if (o0_v !== '0) begin bad++; $display("FAIL mid_rst_v: got %h want 0", o0_v); end
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL mid_rst_rdy: got %0b want 1", in_rdy); end
      step();
      nRST = 1'b1;
      q0.delete();
      q1.delete();
      put(nb);
      repeat (3) step();
      total++; if (q0.size() !== 0) begin bad++; $display("FAIL mid_q0_size: got %0d want 0", q0.size()); end
      total++; if (q1.size() !== 1) begin bad++; $display("FAIL mid_q1_size: got %0d want 1", q1.size()); end
      if (q1.size() == 1) begin
         total++; if (q1[0] !== nb) begin bad++; $display("FAIL mid_hdr: got %h want %h", q1[0], nb); end
      end
      q0.delete();
      q1.delete();
   endtask

`ifdef PKT_DEMUX_PIPE_STATS_EN
   task automatic test_stats();
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      total++; if (st0 !== 32'd0) begin bad++; $display("FAIL stat_rst: got %0d want 0", st0); end
      for (int i = 0; i < 3; i++) put(mk(16'(i), 1'b0, 16'd8));
      put(mk(16'h0900, 1'b1, 16'd32));
      put(mk(16'h0901, 1'b0, 16'd1));
      put(mk(16'h0902, 1'b1, 16'd0));
      repeat (3) step();
      total++; if (st0 !== 32'd3) begin bad++; $display("FAIL stat_pkt0: got %0d want 3", st0); end
      total++; if (st1 !== 32'd2) begin bad++; $display("FAIL stat_pkt1: got %0d want 2", st1); end
      force dut.stat0_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat0_q;
      step();
      put(mk(16'h0A00, 1'b0, 16'd4));
      repeat (3) step();
      total++; if (st0 !== 32'd0) begin bad++; $display("FAIL stat_wrap: got %0d want 0", st0); end
      q0.delete();
      q1.delete();
   endtask
`endif

   initial begin
      total    = 0;
      bad      = 0;
      both_ena = 0;
      nRST     = 1'b0;
      in_ena   = 1'b0;
      in_v     = '0;
      o0_rdy   = 1'b1;
      o1_rdy   = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_long();
      test_reset_mid();
`ifdef PKT_DEMUX_PIPE_STATS_EN
      test_stats();
`endif
      total++; if (both_ena !== 0) begin bad++; $display("FAIL one_hot_ena: both high %0d times want 0", both_ena); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pkt_demux_pipe.md
# pkt_demux_pipe

Packet demultiplexer placed directly downstream of the merge stage. It consumes that stage's 144-bit `{data, length}` beat stream and routes each whole packet to one of two output streams. The destination is chosen by the header beat. The block buffers beats in a 2-entry FIFO so that input ready is registered. It also tracks packet boundaries with a beat counter, so a packet is never split across outputs.

## Interface
- `DATA_WIDTH`, default 128: payload bits per beat; must be a multiple of 8.
- `LEN_WIDTH`, default 16: length field bits.
- `CLK`, input, 1: sole clock.
- `nRST`, input, 1: asynchronous, active-low reset.
- `in$enq__ENA`, input, 1: beat offered; asserted only while `in$enq__RDY` is high.
- `in$enq$v`, input, DATA_WIDTH+LEN_WIDTH: beat; `[LEN_WIDTH-1:0]` is length, upper bits are data.
- `in$enq__RDY`, output, 1: FIFO can accept a beat.
- `out0$enq__ENA`, output, 1: beat delivered to destination 0.
- `out0$enq$v`, output, DATA_WIDTH+LEN_WIDTH: beat, passed unmodified.
- `out0$enq__RDY`, input, 1: destination 0 can accept.
- `out1$enq__ENA`, `out1$enq$v`, `out1$enq__RDY`: same as the out0 ports, for destination 1.
- `stat$pkt0`, `stat$pkt1`, output, 32 each: completed-packet counts; present only with the stats macro.

## Operation
- Beat format: `len = v[LEN_WIDTH-1:0]`, `dest = v[LEN_WIDTH]` (data bit 0). Both fields are meaningful on header beats only.
- Packet length: the header `len` is the total bytes L. The packet has `beats = ceil(L / (DATA_WIDTH/8))` beats; L = 0 is treated as 1 beat.
- Beat count arithmetic: `beats_left = beats - 1`.
  - Counter width is `LEN_WIDTH - log2(DATA_WIDTH/8)` bits, which is 12 at the defaults (maximum 4095).
  - Computed with a shift plus a remainder-nonzero increment; no divider.
- FSM state `HDR`, which is the reset state:
  - When the FIFO head is valid, latch `route = dest` and `beats_left`.
  - Drive the head to `out[dest]` once that output's RDY is high.
  - On dequeue, go to `BODY` if `beats_left != 0`; otherwise stay in `HDR`.
- FSM state `BODY`:
  - Drive the head to `out[route]` when that output's RDY is high.
  - Each dequeue decrements `beats_left`.
  - The dequeue with `beats_left == 1` returns to `HDR`.
  - `len` and `dest` on body beats are ignored.
- Output rules:
  - `outN$enq__ENA = head_valid && selected == N && outN$enq__RDY`.
  - At most one output ENA is high per cycle.
  - The `$v` port of the non-selected output is 0.
- Head-of-line: a stalled destination blocks both outputs. There is no reordering.
- FIFO: 2 entries. `in$enq__RDY = (count < 2)` is registered. Enqueue and dequeue in the same cycle leave count unchanged. There is no bypass when full.

## Timing
- Reset values: `in$enq__RDY = 1`, both `out*$enq__ENA = 0`, both `out*$enq$v = 0`, FIFO empty, state `HDR`, `beats_left = 0`, stats 0.
- Latency: a beat accepted in cycle N can appear on an output in cycle N+1 at the earliest.
- Throughput: 1 beat/cycle sustained when the destination stays ready.
- Full FIFO: `in$enq__RDY` drops the cycle after count reaches 2. It rises the cycle after a dequeue.
- Reset mid-packet: FIFO is flushed, state returns to `HDR`, and the partial packet is abandoned. The first beat after reset is treated as a header.
- Header with L = 0 or L ≤ DATA_WIDTH/8: single-beat packet with no `BODY` visit. Back-to-back headers are accepted every cycle.

## Configuration
- `PKT_DEMUX_PIPE_STATS_EN` defined:
  - Adds `stat$pkt0` and `stat$pkt1`, wrapping 32-bit counters.
  - A counter increments on the dequeue of the last beat of a packet routed to that output.
  - Counters are cleared by `nRST`.
- Undefined: the stat ports and counters are absent. Routing behaviour is identical.

## Structure
- Shared package holds:
  - the beat field widths and the `LEN_LSB`/`DEST_BIT` positions;
  - the `HDR`/`BODY` state enum;
  - a `beats_of(len)` function.
- Sub-module `fifo2`: a 2-entry registered FIFO parameterised by width, with enq/deq/first plus RDY signals. The FSM and routing logic stay in the top level.

## Test plan
- Single header, L = 16, dest = 1, both outputs ready: one `out1` ENA in cycle N+1, `out0` silent, state stays `HDR`.
- L = 40, dest = 0 (3 beats), followed immediately by L = 1, dest = 1: three `out0` beats, then one `out1` beat. Body beats carrying dest = 1 must not be misrouted.
- `out0$enq__RDY` held low for 5 cycles with 3 beats offered: FIFO fills, `in$enq__RDY = 0` after 2 accepts, no beat lost, order preserved after release.
- L = 0 header, then L = 65535 (4096 beats): first is a 1-beat packet; second ends exactly after 4096 dequeues, then returns to `HDR`.
- Async `nRST` pulse mid-`BODY` with 2 beats queued: outputs drop to 0 immediately. The next beat, dest = 1, routes to `out1` as a header.
- With `PKT_DEMUX_PIPE_STATS_EN`: 3 packets to out0 and 2 to out1 give `stat$pkt0 = 3` and `stat$pkt1 = 2`. A counter preset near its maximum wraps to 0.
